// File: rtl/interface_tx.sv
// Debug report transmitter: snapshots PC and cycle count, then streams
// PC, cycles, all registers and the first N_MEM_WORDS memory words to a
// UART transmitter, one byte at a time, least-significant byte first.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for i_send; snapshot PC/cycles on request
// LOAD  | latch current report word into the shift register
// SEND  | pulse o_tx_start for the low byte of the shift register
// WAIT  | wait for i_tx_done; shift to next byte or finish word
// NEXT  | advance word index, or pulse o_done after the last word
module interface_tx #(
    parameter int N_BITS       = 8,
    parameter int N_BITS_REG   = 5,
    parameter int N_BITS_INSTR = 32,
    parameter int N_MEM_WORDS  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_send,
    input  logic [N_BITS_INSTR-1:0] i_pc,
    input  logic [N_BITS_INSTR-1:0] i_cycles,
    output logic [N_BITS_REG-1:0]   o_reg_addr,
    input  logic [N_BITS_INSTR-1:0] i_reg_data,
    output logic [N_BITS_INSTR-1:0] o_mem_addr,
    input  logic [N_BITS_INSTR-1:0] i_mem_data,
    output logic [N_BITS-1:0]       o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_done,
    output logic                    o_busy,
    output logic                    o_done
);

    // Word layout: 0 = PC, 1 = cycles, 2..33 = registers, 34.. = memory.
    localparam int N_REGS   = 32;
    localparam int REG_BASE = 2;
    localparam int MEM_BASE = REG_BASE + N_REGS;
    localparam int N_WORDS  = MEM_BASE + N_MEM_WORDS;
    localparam int IDX_W    = $clog2(N_WORDS);
    localparam int N_BYTES  = N_BITS_INSTR / N_BITS;
    localparam int BIDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [N_BITS_INSTR-1:0] pc_snap_q, pc_snap_d;
    logic [N_BITS_INSTR-1:0] cyc_snap_q, cyc_snap_d;
    logic [N_BITS_INSTR-1:0] shift_q, shift_d;

    logic                    last_word;
    logic                    is_reg_word;
    logic                    is_mem_word;
    logic [IDX_W-1:0]        reg_off;
    logic [IDX_W-1:0]        mem_off;
    logic [N_BITS_INSTR-1:0] cur_word;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            pc_snap_q  <= '0;
            cyc_snap_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            pc_snap_q  <= pc_snap_d;
            cyc_snap_q <= cyc_snap_d;
            shift_q    <= shift_d;
        end
    end

    // Word classification, read-address decode and current-word mux.
    // Addresses are held at 0 while idle so the report sources see a
    // quiet bus between reports.
    always_comb begin
        last_word   = (word_idx_q == IDX_W'(N_WORDS - 1));
        is_reg_word = (word_idx_q >= IDX_W'(REG_BASE)) && (word_idx_q < IDX_W'(MEM_BASE));
        is_mem_word = (word_idx_q >= IDX_W'(MEM_BASE));
        reg_off     = word_idx_q - IDX_W'(REG_BASE);
        mem_off     = word_idx_q - IDX_W'(MEM_BASE);
        o_reg_addr  = '0;
        o_mem_addr  = '0;
        if (state_q != S_IDLE) begin
            if (is_reg_word) begin
                o_reg_addr = N_BITS_REG'(reg_off);
            end
            if (is_mem_word) begin
                o_mem_addr = N_BITS_INSTR'(mem_off);
            end
        end
        if (word_idx_q == IDX_W'(0)) begin
            cur_word = pc_snap_q;
        end else if (word_idx_q == IDX_W'(1)) begin
            cur_word = cyc_snap_q;
        end else if (is_reg_word) begin
            cur_word = i_reg_data;
        end else begin
            cur_word = i_mem_data;
        end
    end

    // Next-state logic and strobes.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        pc_snap_d  = pc_snap_q;
        cyc_snap_d = cyc_snap_q;
        shift_d    = shift_q;
        o_tx_start = 1'b0;
        o_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_send) begin
                    pc_snap_d  = i_pc;
                    cyc_snap_d = i_cycles;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d    = cur_word;
                byte_idx_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                o_tx_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    if (byte_idx_q == BIDX_W'(N_BYTES - 1)) begin
                        state_d = S_NEXT;
                    end else begin
                        shift_d    = shift_q >> N_BITS;
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                        state_d    = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                if (last_word) begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    state_d    = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_tx_data = shift_q[N_BITS-1:0];

endmodule

// File: tb/tb_interface_tx.sv
// Directed bench for interface_tx: a UART responder answers each start
// 10 cycles later, register/memory sources are combinational models.
module tb_interface_tx;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_send;
    logic [31:0] i_pc;
    logic [31:0] i_cycles;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data;
    logic [31:0] o_mem_addr;
    logic [31:0] i_mem_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;

    logic        resp_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        resp_kill = 1'b0;
    int          resp_cnt  = 0;
    int          start_cnt = 0;
    int          done_cnt  = 0;
    logic [7:0]  cap_data[$];
    logic [4:0]  cap_reg[$];
    logic [31:0] cap_mem[$];

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    assign i_reg_data = 32'hA0B0C000 + {27'b0, o_reg_addr};
    assign i_mem_data = 32'h12340000 + o_mem_addr * 32'd3;
    assign i_tx_done  = resp_done | spur_done;

    interface_tx dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_send     (i_send),
        .i_pc       (i_pc),
        .i_cycles   (i_cycles),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (i_reg_data),
        .o_mem_addr (o_mem_addr),
        .i_mem_data (i_mem_data),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Capture starts/done and emulate the UART: done pulse 10 cycles after start.
    always @(negedge i_clk) begin
        resp_done = 1'b0;
        if (o_done) done_cnt++;
        if (resp_kill) begin
            resp_cnt = 0;
        end else if (o_tx_start) begin
            start_cnt++;
            cap_data.push_back(o_tx_data);
            cap_reg.push_back(o_reg_addr);
            cap_mem.push_back(o_mem_addr);
            resp_cnt = 10;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_done = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int w);
        if (w == 0) return 32'h00000010;
        if (w == 1) return 32'h00000005;
        if (w < 34) return 32'hA0B0C000 + 32'(w - 2);
        return 32'h12340000 + 32'(w - 34) * 32'd3;
    endfunction

    initial begin
        logic [31:0] wexp;
        logic [7:0]  bexp;
        logic        seen;
        int          n;
        int          base;

        i_reset  = 1'b1;
        i_send   = 1'b0;
        i_pc     = 32'h0;
        i_cycles = 32'h0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy",     32'(o_busy),     32'h0);
        chk("rst_done",     32'(o_done),     32'h0);
        chk("rst_tx_start", 32'(o_tx_start), 32'h0);
        chk("rst_tx_data",  32'(o_tx_data),  32'h0);
        chk("rst_reg_addr", 32'(o_reg_addr), 32'h0);
        chk("rst_mem_addr", o_mem_addr,      32'h0);
        i_reset = 1'b0;

        // Report 1: latency and snapshot
        @(negedge i_clk);
        i_pc     = 32'h00000010;
        i_cycles = 32'h00000005;
        i_send   = 1'b1;
        @(negedge i_clk);
        i_send   = 1'b0;
        i_pc     = 32'hDEADBEEF;
        i_cycles = 32'hFFFFFFFF;
        chk("load_busy",     32'(o_busy),     32'h1);
        chk("load_no_start", 32'(o_tx_start), 32'h0);
        @(negedge i_clk);
        chk("first_start",   32'(o_tx_start), 32'h1);
        chk("first_byte",    32'(o_tx_data),  32'h10);

        // Run the report with ignored i_send and tx_done pulses during SEND
        seen = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen      = 1'b1;
                i_send    = 1'b1;
                spur_done = 1'b0;
                break;
            end
            i_send    = (c % 7 == 3);
            spur_done = o_tx_start & c[0];
        end
        chk("done_seen", 32'(seen), 32'h1);
        @(negedge i_clk);
        i_send = 1'b0;
        chk("post_done_busy", 32'(o_busy), 32'h0);
        chk("post_done_done", 32'(o_done), 32'h0);
        repeat (5) @(negedge i_clk);
        chk("idle_busy",  32'(o_busy),  32'h0);
        chk("start_cnt",  32'(start_cnt), 32'd264);
        chk("done_cnt",   32'(done_cnt),  32'd1);

        chk("b0", 32'(cap_data[0]), 32'h10);
        chk("b1", 32'(cap_data[1]), 32'h00);
        chk("b2", 32'(cap_data[2]), 32'h00);
        chk("b3", 32'(cap_data[3]), 32'h00);
        chk("b4", 32'(cap_data[4]), 32'h05);
        chk("b5", 32'(cap_data[5]), 32'h00);
        chk("b6", 32'(cap_data[6]), 32'h00);
        chk("b7", 32'(cap_data[7]), 32'h00);
        chk("r31_b0", 32'(cap_data[132]), 32'h1F);
        chk("r31_b1", 32'(cap_data[133]), 32'hC0);
        chk("r31_b2", 32'(cap_data[134]), 32'hB0);
        chk("r31_b3", 32'(cap_data[135]), 32'hA0);
        chk("m31_b0", 32'(cap_data[260]), 32'h5D);
        chk("m31_b3", 32'(cap_data[263]), 32'h12);

        for (int i = 0; i < 264 && i < cap_data.size(); i++) begin
            wexp = exp_word(i / 4);
            bexp = wexp[8*(i%4) +: 8];
            chk($sformatf("byte%0d", i), 32'(cap_data[i]), 32'(bexp));
            if (i / 4 >= 2 && i / 4 < 34)
                chk($sformatf("reg_addr%0d", i), 32'(cap_reg[i]), 32'(i / 4 - 2));
            else
                chk($sformatf("reg_addr_zero%0d", i), 32'(cap_reg[i]), 32'h0);
            if (i / 4 >= 34)
                chk($sformatf("mem_addr%0d", i), cap_mem[i], 32'(i / 4 - 34));
            else
                chk($sformatf("mem_addr_zero%0d", i), cap_mem[i], 32'h0);
        end

        // Report 2: reset mid-report, together with i_send
        i_pc     = 32'h00000077;
        i_cycles = 32'h00000099;
        @(negedge i_clk);
        i_send = 1'b1;
        @(negedge i_clk);
        i_send = 1'b0;
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge i_clk);
            if (o_tx_start) n++;
            if (n == 6) break;
        end
        chk("reached_byte5", 32'(n), 32'd6);
        i_reset   = 1'b1;
        i_send    = 1'b1;
        resp_kill = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_tx_start", 32'(o_tx_start), 32'h0);
        chk("mid_rst_tx_data",  32'(o_tx_data),  32'h0);
        chk("mid_rst_busy",     32'(o_busy),     32'h0);
        chk("mid_rst_done",     32'(o_done),     32'h0);
        chk("mid_rst_reg_addr", 32'(o_reg_addr), 32'h0);
        chk("mid_rst_mem_addr", o_mem_addr,      32'h0);
        base      = start_cnt;
        i_reset   = 1'b0;
        i_send    = 1'b0;
        resp_kill = 1'b0;
        repeat (20) @(negedge i_clk);
        chk("no_bytes_after_rst", 32'(start_cnt), 32'(base));
        chk("idle_after_rst",     32'(o_busy),    32'h0);

        i_send = 1'b1;
        @(negedge i_clk);
        i_send = 1'b0;
        chk("restart_busy", 32'(o_busy), 32'h1);
        @(negedge i_clk);
        chk("restart_start", 32'(o_tx_start), 32'h1);
        chk("restart_byte0", 32'(o_tx_data),  32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
